// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared state type and one-hot helpers for NoC output arbiters
package noc_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Rotate a one-hot vector left by one within its low n bits, MSB wrapping to bit 0.
  function automatic logic [MAX_REQ-1:0] rotl1_onehot(input logic [MAX_REQ-1:0] v, input int n);
    logic [MAX_REQ-1:0] r;
    r = (v << 1) | (v >> (n - 1));
    r = r & MAX_REQ'((32'd1 << n) - 32'd1);
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] onehot2bin(input logic [MAX_REQ-1:0] v);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) b = b | IDX_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// rtl/rr_pick_onehot.sv - circular priority picker, ptr bit has highest priority
module rr_pick_onehot #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dmask;

  // Subtracting ptr from the doubled request clears the first set bit at or above ptr,
  // so and-not isolates it; the upper copy catches the wrap-around case.
  always_comb begin
    dreq  = {req, req};
    dmask = dreq & ~(dreq - {{N{1'b0}}, ptr});
    pick  = dmask[N-1:0] | dmask[2*N-1:N];
  end

endmodule

// File: rtl/rr_arbiter_lock_n.sv
// rtl/rr_arbiter_lock_n.sv - N-input round-robin output arbiter with wormhole lock and stall timeout
module rr_arbiter_lock_n
  import noc_arb_pkg::*;
#(
  parameter int N_REQ        = 5,
  parameter bit LOCK_EN      = 1'b1,
  parameter int TIMEOUT_W    = 8,
  parameter int LOCK_TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     out_ready,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int                   OWN_W      = $clog2(N_REQ);
  localparam logic [TIMEOUT_W-1:0] STALL_LAST = TIMEOUT_W'(LOCK_TIMEOUT - 1);
  localparam bit                   TIMEOUT_ON = (LOCK_TIMEOUT != 0);

  arb_state_t           state;
  logic [N_REQ-1:0]     ptr;
  logic [N_REQ-1:0]     pick;
  logic [N_REQ-1:0]     owner_oh;
  logic [TIMEOUT_W-1:0] stall_cnt;
  logic [MAX_REQ-1:0]   gnt_ext;
  logic                 xfer_ok;
  logic                 owner_req;
  logic                 stall_expire;

  rr_pick_onehot #(.N(N_REQ)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    xfer_ok         = en && out_ready && !reset;
    owner_req       = |(req & owner_oh);
    gnt             = '0;
    if (xfer_ok) begin
      if (state == ARB_IDLE) gnt = pick;
      else if (owner_req)    gnt = owner_oh;
    end
    // A grant or a source abort on the same cycle takes precedence over the timeout.
    stall_expire = TIMEOUT_ON && !reset && (state == ARB_LOCKED) && owner_req &&
                   (gnt == '0) && (stall_cnt == STALL_LAST);
    gnt_ext              = '0;
    gnt_ext[N_REQ-1:0]   = gnt;
  end

  assign busy        = (state == ARB_LOCKED);
  assign timeout_err = stall_expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      ptr       <= N_REQ'(1);
      owner     <= '0;
      stall_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      stall_cnt <= '0;
      if (gnt != '0) begin
        ptr <= N_REQ'(rotl1_onehot(gnt_ext, N_REQ));
        if (LOCK_EN && ((gnt & last) == '0)) begin
          state <= ARB_LOCKED;
          owner <= OWN_W'(onehot2bin(gnt_ext));
        end
      end
    end else begin
      if (!owner_req) begin
        state     <= ARB_IDLE;
        stall_cnt <= '0;
      end else if (gnt != '0) begin
        stall_cnt <= '0;
        if ((gnt & last) != '0) state <= ARB_IDLE;
      end else if (stall_expire) begin
        state     <= ARB_IDLE;
        stall_cnt <= '0;
      end else if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + TIMEOUT_W'(1);
      end
    end
  end

endmodule
